// File: rtl/mxv_pkg.sv
// Shared definitions for the MxV pass scheduler.
// Holds the scheduler state encoding, the default geometry constants, and
// helper functions for pass count and FIFO-group select width.
package mxv_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CHECK,
    SETTLE,
    CLEAR,
    POP,
    MAC,
    FLUSH,
    RESULT,
    DONE,
    HOLD
  } sched_state_e;

  localparam int unsigned MXV_LANES      = 4;
  localparam int unsigned MXV_MAX_N      = 8;
  localparam int unsigned MXV_SETTLE_CYC = 5;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  // Width of the FIFO group / pass index; never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned max_n, input int unsigned lanes);
    int unsigned groups;
    groups = ceil_div(max_n, lanes);
    return (groups > 1) ? $clog2(groups) : 1;
  endfunction

  localparam int unsigned MXV_PW = sel_width(MXV_MAX_N, MXV_LANES);

endpackage

// File: rtl/mxv_pass_scheduler_if.sv
// Control bundle between the pass scheduler, the start/N registers, the FIFO
// bank, the MAC array and the result consumer.
//   start, N        : job request and matrix dimension
//   busy, done, err : job status
//   reset_ope       : operand-register clear
//   sys_reset       : accumulator clear
//   pop, operation  : FIFO pop and MAC enable
//   fifo_sel        : FIFO group / pass index
//   res_valid/ready : pass result handshake
// The master modport is the scheduler side.
interface mxv_pass_scheduler_if
  import mxv_pkg::*;
#(
  parameter int unsigned PW = MXV_PW
);
  logic          start;
  logic [7:0]    N;
  logic          busy;
  logic          done;
  logic          err;
  logic          reset_ope;
  logic          sys_reset;
  logic          pop;
  logic          operation;
  logic [PW-1:0] fifo_sel;
  logic          res_valid;
  logic          res_ready;

  modport master (
    input  start, N, res_ready,
    output busy, done, err, reset_ope, sys_reset, pop, operation, fifo_sel, res_valid
  );

  modport slave (
    output start, N, res_ready,
    input  busy, done, err, reset_ope, sys_reset, pop, operation, fifo_sel, res_valid
  );
endinterface

// File: rtl/mxv_step_counter.sv
// Loadable down-counter with terminal-count flag.
//   clk, reset   : clock, synchronous active-high reset (count to 0)
//   load_i       : load load_value_i (takes priority over enable_i)
//   load_value_i : value loaded
//   enable_i     : decrement by one; holds at zero
//   tc_o         : count is zero
module mxv_step_counter
  import mxv_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             enable_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (enable_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/mxv_pass_scheduler.sv
// Counter-based sequencer for the MxV datapath. One pass per LANES rows:
// settle, clear the accumulators, alternate pop/MAC N times, flush the MAC
// pipeline, then hand the pass result over a valid/ready handshake.
//   clk, reset : clock, synchronous active-high reset
//   bus        : master side of mxv_pass_scheduler_if (see interface header)
// All outputs are decoded from registered state and counters.
module mxv_pass_scheduler
  import mxv_pkg::*;
#(
  parameter int unsigned LANES      = MXV_LANES,
  parameter int unsigned MAX_N      = MXV_MAX_N,
  parameter int unsigned SETTLE_CYC = MXV_SETTLE_CYC
) (
  input  logic                  clk,
  input  logic                  reset,
  mxv_pass_scheduler_if.master  bus
);

  localparam int unsigned PW = sel_width(MAX_N, LANES);
  localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  sched_state_e  state_q, state_d;
  logic [7:0]    n_q, n_d;
  logic [7:0]    passes_q, passes_d;
  logic [PW-1:0] pass_q, pass_d;
  logic          err_q, err_d;

  logic settleLoad, settleTc;
  logic elemTc;
  logic lastPass;

  // The settle counter reloads whenever a pass begins, from CHECK or from a
  // completed handshake, so it runs exactly SETTLE_CYC cycles each pass.
  assign settleLoad = (state_d == SETTLE) && (state_q != SETTLE);

  mxv_step_counter #(.WIDTH(SW)) settleCounter (
    .clk          (clk),
    .reset        (reset),
    .load_i       (settleLoad),
    .load_value_i (SW'(SETTLE_CYC - 1)),
    .enable_i     (state_q == SETTLE),
    .tc_o         (settleTc)
  );

  // Loaded in CLEAR with n-1; reaching zero in a MAC cycle marks the last element.
  mxv_step_counter #(.WIDTH(8)) elemCounter (
    .clk          (clk),
    .reset        (reset),
    .load_i       (state_q == CLEAR),
    .load_value_i (n_q - 8'd1),
    .enable_i     (state_q == MAC),
    .tc_o         (elemTc)
  );

  assign lastPass = ((8'(pass_q) + 8'd1) == passes_q);

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    passes_d = passes_q;
    pass_d   = pass_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = CHECK;
          n_d      = bus.N;
          passes_d = 8'(ceil_div(32'(bus.N), LANES));
          pass_d   = '0;
          err_d    = 1'b0;
        end
      end
      CHECK: begin
        if ((n_q == 8'd0) || (32'(n_q) > MAX_N)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = SETTLE;
        end
      end
      SETTLE:  if (settleTc) state_d = CLEAR;
      CLEAR:   state_d = POP;
      POP:     state_d = MAC;
      MAC:     state_d = elemTc ? FLUSH : POP;
      FLUSH:   state_d = RESULT;
      RESULT: begin
        if (bus.res_ready) begin
          if (lastPass) begin
            state_d = DONE;
          end else begin
            pass_d  = pass_q + 1'b1;
            state_d = SETTLE;
          end
        end
      end
      DONE:    state_d = HOLD;
      HOLD:    if (!bus.start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      n_q      <= '0;
      passes_q <= '0;
      pass_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      passes_q <= passes_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
    end
  end

  assign bus.busy      = state_q inside {CHECK, SETTLE, CLEAR, POP, MAC, FLUSH, RESULT, DONE};
  assign bus.done      = (state_q == DONE);
  assign bus.err       = (state_q == DONE) && err_q;
  assign bus.reset_ope = (state_q == SETTLE) && settleTc;
  assign bus.sys_reset = (state_q == CLEAR);
  assign bus.pop       = (state_q == POP);
  assign bus.operation = (state_q == MAC) || (state_q == FLUSH);
  assign bus.res_valid = (state_q == RESULT);
  assign bus.fifo_sel  = (state_q inside {SETTLE, CLEAR, POP, MAC, FLUSH, RESULT}) ? pass_q : '0;

endmodule

// File: tb/tb_mxv_pass_scheduler.sv
// Directed bench for mxv_pass_scheduler. Each job pushes its expected
// schedule summary into a scoreboard queue; when the job's done pulse
// appears, the observed summary is compared against the popped entry.
module tb_mxv_pass_scheduler;
  import mxv_pkg::*;

  localparam int unsigned PW = sel_width(MXV_MAX_N, MXV_LANES);

  logic clk = 1'b0;
  logic reset;

  mxv_pass_scheduler_if #(.PW(PW)) bus ();

  mxv_pass_scheduler #(
    .LANES      (MXV_LANES),
    .MAX_N      (MXV_MAX_N),
    .SETTLE_CYC (MXV_SETTLE_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int doneCycle;
    int err;
    int pops;
    int ops;
    int sys;
    int ope;
    int valid;
    int busy;
    int popsSel;
    int firstSys;
    int firstPop;
    int firstOp;
    int firstValid;
  } exp_t;

  exp_t sbQueue[$];
  int   nAsserts = 0;
  int   nFail    = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string prefix);
    checkOutput({prefix, "_busy"},      32'(bus.busy),      32'd0);
    checkOutput({prefix, "_done"},      32'(bus.done),      32'd0);
    checkOutput({prefix, "_err"},       32'(bus.err),       32'd0);
    checkOutput({prefix, "_reset_ope"}, 32'(bus.reset_ope), 32'd0);
    checkOutput({prefix, "_sys_reset"}, 32'(bus.sys_reset), 32'd0);
    checkOutput({prefix, "_pop"},       32'(bus.pop),       32'd0);
    checkOutput({prefix, "_operation"}, 32'(bus.operation), 32'd0);
    checkOutput({prefix, "_fifo_sel"},  32'(bus.fifo_sel),  32'd0);
    checkOutput({prefix, "_res_valid"}, 32'(bus.res_valid), 32'd0);
  endtask

  // Expected schedule, relative to the cycle start is sampled (cycle 0).
  // A pass is SETTLE + CLEAR + n pop/MAC pairs + FLUSH + RESULT.
  task automatic pushExpected(input int n, input int stall);
    exp_t e;
    bit   legal;
    int   passes;
    int   passLen;
    legal   = (n >= 1) && (n <= int'(MXV_MAX_N));
    passes  = legal ? (n + int'(MXV_LANES) - 1) / int'(MXV_LANES) : 0;
    passLen = int'(MXV_SETTLE_CYC) + 1 + 2 * n + 1 + 1;
    e.doneCycle  = legal ? 2 + passes * passLen + stall : 2;
    e.err        = legal ? 0 : 1;
    e.pops       = passes * n;
    e.ops        = passes * (n + 1);
    e.sys        = passes;
    e.ope        = passes;
    e.valid      = legal ? passes + stall : 0;
    e.busy       = e.doneCycle;
    e.popsSel    = (passes > 1) ? (passes - 1) * n : 0;
    e.firstSys   = legal ? 2 + int'(MXV_SETTLE_CYC) : -1;
    e.firstPop   = legal ? 3 + int'(MXV_SETTLE_CYC) : -1;
    e.firstOp    = legal ? 4 + int'(MXV_SETTLE_CYC) : -1;
    e.firstValid = legal ? 2 + int'(MXV_SETTLE_CYC) + 1 + 2 * n + 1 : -1;
    sbQueue.push_back(e);
  endtask

  // Runs one job; res_ready is held low for 'stall' cycles of the final RESULT.
  task automatic applyStimulus(input int n, input int stall, input bit holdStart, input string name);
    exp_t e;
    int rel, stallLeft, doneRel, errAtDone;
    int pops, ops, sys, ope, valid, busy, popsSel, overlap;
    int firstSys, firstPop, firstOp, firstValid;
    int selAtDone;
    bit seenDone;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    pushExpected(n, stall);
    bus.start     = 1'b1;
    bus.N         = 8'(n);
    bus.res_ready = (stall == 0);
    stallLeft = stall;
    rel = 0; doneRel = -1; errAtDone = -1; selAtDone = -1;
    pops = 0; ops = 0; sys = 0; ope = 0; valid = 0; busy = 0; popsSel = 0; overlap = 0;
    firstSys = -1; firstPop = -1; firstOp = -1; firstValid = -1;
    seenDone = 1'b0;
    while (!seenDone && rel < 300) begin
      @(negedge clk);
      rel++;
      if (rel == 1) begin
        bus.N = 8'hFF;
        if (!holdStart) bus.start = 1'b0;
      end
      if (bus.pop) begin
        pops++;
        if (firstPop < 0) firstPop = rel;
        if (bus.fifo_sel != '0) popsSel++;
      end
      if (bus.operation) begin
        ops++;
        if (firstOp < 0) firstOp = rel;
      end
      if (bus.sys_reset) begin
        sys++;
        if (firstSys < 0) firstSys = rel;
      end
      if (bus.reset_ope) ope++;
      if (bus.busy) busy++;
      if (bus.res_valid) begin
        valid++;
        if (firstValid < 0) firstValid = rel;
      end
      if (bus.pop && bus.operation) overlap++;
      if (bus.sys_reset && bus.reset_ope) overlap++;
      if (bus.res_valid && !bus.res_ready) begin
        if (stallLeft == 0) bus.res_ready = 1'b1;
        else stallLeft--;
      end
      if (bus.done) begin
        seenDone  = 1'b1;
        doneRel   = rel;
        errAtDone = int'(bus.err);
        selAtDone = int'(bus.fifo_sel);
      end
    end
    checkOutput({name, "_done_seen"}, 32'(seenDone), 32'd1);
    if (sbQueue.size() == 0) begin
      checkOutput({name, "_scoreboard_entry"}, 32'd0, 32'd1);
    end else begin
      e = sbQueue.pop_front();
      checkOutput({name, "_done_cycle"},  doneRel,    e.doneCycle);
      checkOutput({name, "_err"},         errAtDone,  e.err);
      checkOutput({name, "_pops"},        pops,       e.pops);
      checkOutput({name, "_ops"},         ops,        e.ops);
      checkOutput({name, "_sys_reset"},   sys,        e.sys);
      checkOutput({name, "_reset_ope"},   ope,        e.ope);
      checkOutput({name, "_valid"},       valid,      e.valid);
      checkOutput({name, "_busy"},        busy,       e.busy);
      checkOutput({name, "_pops_sel1"},   popsSel,    e.popsSel);
      checkOutput({name, "_first_sys"},   firstSys,   e.firstSys);
      checkOutput({name, "_first_pop"},   firstPop,   e.firstPop);
      checkOutput({name, "_first_op"},    firstOp,    e.firstOp);
      checkOutput({name, "_first_valid"}, firstValid, e.firstValid);
      checkOutput({name, "_overlap"},     overlap,    32'd0);
      checkOutput({name, "_sel_at_done"}, selAtDone,  32'd0);
    end
    @(negedge clk);
    checkOutput({name, "_done_pulse_end"}, 32'(bus.done), 32'd0);
    checkOutput({name, "_busy_after"},     32'(bus.busy), 32'd0);
    bus.res_ready = 1'b1;
  endtask

  initial begin
    int rel, opSeen, busyCnt;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.N         = 8'd0;
    bus.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkAllZero("reset_hold");
    reset = 1'b0;
    @(negedge clk);
    checkAllZero("reset_release");

    applyStimulus(1, 0, 1'b0, "n1");
    applyStimulus(8, 0, 1'b0, "n8");
    applyStimulus(0, 0, 1'b0, "n0");
    applyStimulus(9, 0, 1'b0, "n9");
    applyStimulus(4, 3, 1'b0, "n4_stall");

    // Abort a job on its third MAC cycle.
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.N     = 8'd4;
    rel = 0; opSeen = 0;
    while (opSeen < 3 && rel < 100) begin
      @(negedge clk);
      rel++;
      if (rel == 1) bus.start = 1'b0;
      if (bus.operation) opSeen++;
    end
    checkOutput("midrun_third_mac_cycle", rel, 32'd13);
    reset = 1'b1;
    @(negedge clk);
    checkAllZero("midrun_reset");
    reset = 1'b0;
    applyStimulus(2, 0, 1'b0, "n2_after_reset");

    // start stays high across DONE: no second run until it drops.
    applyStimulus(4, 0, 1'b1, "hold");
    busyCnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.busy) busyCnt++;
    end
    checkOutput("hold_no_retrigger", busyCnt, 32'd0);
    applyStimulus(3, 0, 1'b0, "n3_retrigger");

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/mxv_pass_scheduler.md
# mxv_pass_scheduler

Parameterised sequencer for the matrix-vector (MxV) datapath: replaces the fixed unrolled step sequence with counters so any N from 1 to MAX_N is handled. Runs one pass per group of LANES rows. Each pass settles the array, clears it, pops and multiplies N vector/matrix elements, flushes the pipeline and hands the pass result to a downstream consumer over a valid/ready handshake. Sits between the top-level start/N registers and the FIFO bank plus MAC array.

## Interface
- LANES, 4, MAC lanes (rows) computed per pass
- MAX_N, 8, largest legal N; MAX_N ≥ 1
- SETTLE_CYC, 5, settle cycles at the start of each pass; ≥ 1
- clk  in  1  system clock
- reset  in  1  reset; one clock; synchronous, active-high
- start  in  1  level request; sampled only in IDLE
- N  in  8  matrix dimension; latched when start is accepted
- busy  out  1  high from acceptance until DONE inclusive
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies done: 1 = N illegal, nothing executed
- reset_ope  out  1  operand-register clear, last settle cycle
- sys_reset  out  1  accumulator clear, one cycle per pass
- pop  out  1  pop one element from the selected FIFO group
- operation  out  1  MAC enable
- fifo_sel  out  PW = max(1,$clog2(ceil(MAX_N/LANES)))  FIFO group / pass index
- res_valid  out  1  pass result available
- res_ready  in  1  consumer accepts result

## Operation
- Latched values: n_q (8 b), passes = ceil(n_q/LANES) computed once at acceptance, pass counter (PW b), element counter k (8 b), settle counter.
- States and transitions:
  - IDLE: start=1 → CHECK.
  - CHECK: n_q==0 or n_q>MAX_N → DONE with err=1; otherwise SETTLE.
  - SETTLE: SETTLE_CYC cycles. reset_ope=1 on the last cycle. Then → CLEAR.
  - CLEAR: sys_reset=1 for one cycle; k←0; → POP.
  - POP: pop=1; → MAC.
  - MAC: operation=1; k++. If k==n_q-1 → FLUSH, else → POP.
  - FLUSH: operation=1 for one cycle, to drain the MAC pipeline; → RESULT.
  - RESULT: res_valid=1, held stable until res_ready=1 in the same cycle. On that handshake: last pass → DONE; otherwise pass++ and → SETTLE.
  - DONE: done=1 for one cycle; → HOLD.
  - HOLD: stays until start=0, then → IDLE. start held high never retriggers.
- fifo_sel equals the pass counter in SETTLE..RESULT. It is 0 in IDLE, CHECK, DONE and HOLD.
- pop and operation are never high in the same cycle. sys_reset and reset_ope are never high in the same cycle.
- Reset, including mid-pass: next state IDLE, all counters 0. Every output is 0 on the cycle after reset: busy, done, err, reset_ope, sys_reset, pop, operation, fifo_sel, res_valid.
- start and N changes while busy are ignored. n_q is unaffected.

## Timing
- All outputs are Moore, decoded from registered state/counters. No input-to-output combinational path, except that res_valid drop follows the sampled res_ready edge.
- Cycle 0: start sampled high in IDLE. Cycle 1: CHECK. SETTLE begins at cycle 2.
- Pass length with res_ready tied high: SETTLE_CYC + 1 + 2·n + 1 + 1 cycles.
- n=8, LANES=4, defaults, res_ready=1: 2 passes × 24 = 48 cycles (cycles 2..49); done at cycle 50.
- Illegal N: done and err high at cycle 2.
- Each cycle res_ready is held low adds exactly one cycle to the schedule.
- The first pop follows sys_reset by exactly one cycle. Each operation follows its pop by exactly one cycle.

## Structure
- mxv_pkg:
  - state enum sched_state_e: IDLE, CHECK, SETTLE, CLEAR, POP, MAC, FLUSH, RESULT, DONE, HOLD
  - default constants MXV_LANES, MXV_MAX_N, MXV_SETTLE_CYC
  - function ceil_div for the passes computation
- One sub-module: mxv_step_counter, a loadable down-counter with terminal-count flag (sync reset, load, enable). Instantiated for the settle and element counts.
- Pass counter stays inline.

## Test plan
- N=1, res_ready=1 → pop at cycle 8, operation at cycles 9–10, res_valid at 11, done at 12, fifo_sel=0 throughout.
- N=8, res_ready=1 → 16 pops, 18 operation cycles, fifo_sel 0 then 1, two res_valid pulses, done at cycle 50, err=0.
- N=0 and N=9 → done+err at cycle 2; pop, operation, sys_reset and reset_ope stay 0.
- N=4 with res_ready low for 3 cycles in RESULT → res_valid held 4 cycles, done delayed by exactly 3 cycles.
- Reset asserted on the 3rd MAC cycle → all outputs 0 next cycle. A restart with N=2 then completes normally.
- start held high across DONE → exactly one run. Dropping start then reasserting it → second run starts.
